// File: rtl/axis_y_packer_pkg.sv
// axis_y_packer_pkg
//   Shared types and helpers for the Y-stream to AXI-Stream packer.
//   pack_mode  : selects pass-through, upsize or downsize from the two widths
//   pack_ratio : packing ratio K = max(w_in, axi_width) / min(w_in, axi_width)
//   keep_mask  : low n_bytes bits set, clipped to keep_w, KEEP_MAX bits wide
package axis_y_packer_pkg;

    typedef enum logic [1:0] {PK_PASS, PK_UP, PK_DOWN} pack_mode_e;

    // Widest tkeep the helper can build (AXI_WIDTH up to 1024 bits).
    localparam int KEEP_MAX = 128;

    function automatic pack_mode_e pack_mode(input int w_in, input int axi_width);
        if (w_in == axi_width)
            return PK_PASS;
        else if (axi_width > w_in)
            return PK_UP;
        else
            return PK_DOWN;
    endfunction

    function automatic int pack_ratio(input int w_in, input int axi_width);
        return (w_in > axi_width) ? (w_in / axi_width) : (axi_width / w_in);
    endfunction

    function automatic logic [KEEP_MAX-1:0] keep_mask(input int n_bytes, input int keep_w);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < n_bytes && i < keep_w)
                m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_y_packer_out_reg.sv
// axis_y_out_reg
//   Output holding register for the packer: one AXI-Stream beat with
//   valid/ready. A load takes priority over draining; the parent only loads
//   when free is high, so a held beat is never overwritten.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load, load_data/keep/last     beat to capture at the next rising edge
//   m_axis_tdata/tkeep/tvalid/tlast  registered stream outputs
//   m_axis_tready                 sink ready
//   free                          register is empty or drains this cycle
module axis_y_out_reg #(
    parameter int AXI_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [AXI_WIDTH-1:0]   load_data,
    input  logic [AXI_WIDTH/8-1:0] load_keep,
    input  logic                   load_last,
    output logic [AXI_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   free
);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= load_data;
            m_axis_tkeep  <= load_keep;
            m_axis_tlast  <= load_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end
    end

    assign free = !m_axis_tvalid || m_axis_tready;

endmodule

// File: rtl/axis_y_packer.sv
// axis_y_packer
//   Repacks R-lane x WY-bit Y vectors into AXI_WIDTH-bit AXI-Stream beats
//   (tkeep/tlast) for the S2MM write channel. Upsize packs K vectors per
//   beat (first vector in the LSBs); downsize emits one vector as K beats,
//   low slice first; equal widths give a single registered stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast   Y vector input, lane 0 in LSBs
//   m_axis_tdata/tkeep/tvalid/tready/tlast  packed output stream
//   beat_count, xfer_count   only with AXIS_Y_PACKER_CNT_EN defined: number
//                            of output handshakes / of tlast beats (wrapping)
// Build option: define AXIS_Y_PACKER_CNT_EN to add the two counters.
module axis_y_packer
    import axis_y_packer_pkg::*;
#(
    parameter int R         = 8,
    parameter int WY        = 32,
    parameter int AXI_WIDTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [R*WY-1:0]        s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [AXI_WIDTH-1:0]   m_axis_tdata,
    output logic [AXI_WIDTH/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
`ifdef AXIS_Y_PACKER_CNT_EN
    output logic [31:0]            beat_count,
    output logic [15:0]            xfer_count,
`endif
    output logic                   m_axis_tlast
);

    localparam int         W_IN   = R * WY;
    localparam int         KEEP_W = AXI_WIDTH / 8;
    localparam pack_mode_e MODE   = pack_mode(W_IN, AXI_WIDTH);
    localparam int         K      = pack_ratio(W_IN, AXI_WIDTH);

    if ((W_IN % 8) != 0 || (AXI_WIDTH % 8) != 0) begin : g_bad_bytes
        $fatal(1, "axis_y_packer: W_IN and AXI_WIDTH must be byte multiples");
    end
    if ((W_IN % AXI_WIDTH) != 0 && (AXI_WIDTH % W_IN) != 0) begin : g_bad_ratio
        $fatal(1, "axis_y_packer: W_IN and AXI_WIDTH must divide one another");
    end
    if (KEEP_W > KEEP_MAX) begin : g_bad_keep
        $fatal(1, "axis_y_packer: AXI_WIDTH too wide for keep_mask");
    end

    logic                 load;
    logic [AXI_WIDTH-1:0] load_data;
    logic [KEEP_W-1:0]    load_keep;
    logic                 load_last;
    logic                 free;

    axis_y_out_reg #(.AXI_WIDTH(AXI_WIDTH)) u_out_reg (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .load_data     (load_data),
        .load_keep     (load_keep),
        .load_last     (load_last),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .free          (free)
    );

    if (MODE == PK_DOWN) begin : g_down
        localparam int IDX_W = $clog2(K);

        logic [W_IN-1:0]  sr;         // slices not yet handed to the output register
        logic [IDX_W-1:0] idx;        // slice currently held in the output register
        logic             busy;
        logic             word_last;
        logic             at_last;
        logic             in_fire;
        logic             out_fire;

        assign at_last  = (idx == IDX_W'(K - 1));
        // While the final slice is held the output register is full, so free
        // equals m_axis_tready there.
        assign s_axis_tready = !busy || (at_last && free);
        assign in_fire  = s_axis_tvalid && s_axis_tready;
        assign out_fire = m_axis_tvalid && m_axis_tready;

        // A new word and a slice advance can never coincide: a word is only
        // accepted when nothing or the final slice is held.
        always_comb begin
            load      = in_fire || (out_fire && !at_last);
            load_data = in_fire ? s_axis_tdata[AXI_WIDTH-1:0] : sr[AXI_WIDTH-1:0];
            load_keep = '1;
            load_last = in_fire ? 1'b0 : (word_last && idx == IDX_W'(K - 2));
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sr        <= '0;
                idx       <= '0;
                busy      <= 1'b0;
                word_last <= 1'b0;
            end else if (in_fire) begin
                sr        <= s_axis_tdata >> AXI_WIDTH;
                idx       <= '0;
                busy      <= 1'b1;
                word_last <= s_axis_tlast;
            end else if (out_fire) begin
                if (at_last) begin
                    busy <= 1'b0;
                end else begin
                    idx <= idx + IDX_W'(1);
                    sr  <= sr >> AXI_WIDTH;
                end
            end
        end
    end else begin : g_up
        // Also covers K == 1: cnt stays at 0 and every accept completes a beat.
        localparam int CNT_W = (K > 1) ? $clog2(K) : 1;

        logic [AXI_WIDTH-1:0] acc;
        logic [CNT_W-1:0]     cnt;
        logic [AXI_WIDTH-1:0] word_at_cnt;
        logic                 in_fire;
        logic                 done;

        assign s_axis_tready = free;
        assign in_fire     = s_axis_tvalid && s_axis_tready;
        assign done        = (cnt == CNT_W'(K - 1)) || s_axis_tlast;
        assign word_at_cnt = AXI_WIDTH'(s_axis_tdata) << (int'(cnt) * W_IN);

        // Slots above cnt are zero because acc is cleared on every completed beat.
        always_comb begin
            load      = in_fire && done;
            load_data = acc | word_at_cnt;
            load_keep = KEEP_W'(keep_mask((int'(cnt) + 1) * W_IN / 8, KEEP_W));
            load_last = s_axis_tlast;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                acc <= '0;
                cnt <= '0;
            end else if (in_fire) begin
                if (done) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc | word_at_cnt;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef AXIS_Y_PACKER_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_count <= '0;
            xfer_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            beat_count <= beat_count + 32'd1;
            if (m_axis_tlast)
                xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_y_packer.sv
// Bench for axis_y_packer: three instances (upsize K=4, downsize K=2,
// pass-through K=1) each checked against a byte-stream model every cycle,
// plus directed transfers with literal expected beats.
module tb_axis_y_packer;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  k;
        logic         l;
    } beat_t;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic         rst_a     [3];
    logic [255:0] s_data_a  [3];
    logic         s_valid_a [3];
    logic         s_last_a  [3];
    logic         m_ready_a [3];
    logic         s_ready_a [3];
    logic         m_valid_a [3];
    logic         m_last_a  [3];
    logic [255:0] m_data_a  [3];
    logic [31:0]  m_keep_a  [3];
    logic [31:0]  bc_a      [3];
    logic [15:0]  xc_a      [3];

    beat_t cap [3][$];
    int    pend_n   [3];
    int    vrun_max [3];
    bit    rnd_ready[3];

    function automatic void chk(input string nm, input int g,
                                input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, g, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_i
        localparam int CR  = (g == 0) ? 2 : 4;
        localparam int CWY = (g == 0) ? 16 : 32;
        localparam int CAW = (g == 1) ? 64 : 128;
        localparam int W   = CR * CWY;
        localparam int WB  = W / 8;
        localparam int AB  = CAW / 8;
        localparam bit UPM = (W <= CAW);

        logic [W-1:0]     sd;
        logic [CAW-1:0]   md;
        logic [CAW/8-1:0] mk;
        logic             srdy, mv, ml;
        logic [31:0]      bc;
        logic [15:0]      xc;

        assign sd = s_data_a[g][W-1:0];

        axis_y_packer #(.R(CR), .WY(CWY), .AXI_WIDTH(CAW)) dut (
            .clk           (clk),
            .rst           (rst_a[g]),
            .s_axis_tdata  (sd),
            .s_axis_tvalid (s_valid_a[g]),
            .s_axis_tready (srdy),
            .s_axis_tlast  (s_last_a[g]),
            .m_axis_tdata  (md),
            .m_axis_tkeep  (mk),
            .m_axis_tvalid (mv),
            .m_axis_tready (m_ready_a[g]),
`ifdef AXIS_Y_PACKER_CNT_EN
            .beat_count    (bc),
            .xfer_count    (xc),
`endif
            .m_axis_tlast  (ml)
        );

`ifndef AXIS_Y_PACKER_CNT_EN
        assign bc = '0;
        assign xc = '0;
`endif
        assign s_ready_a[g] = srdy;
        assign m_valid_a[g] = mv;
        assign m_last_a[g]  = ml;
        assign m_data_a[g]  = 256'(md);
        assign m_keep_a[g]  = 32'(mk);
        assign bc_a[g]      = bc;
        assign xc_a[g]      = xc;

        // Model: queue of beats the DUT still owes, built from accepted bytes.
        beat_t        expq[$];
        logic [7:0]   pend[$];
        int           nw = 0, cyc = 0, t_acc = -10, run = 0;
        logic         pv = 0, pr = 0, pl = 0;
        logic [255:0] pd = '0;
        logic [31:0]  pk = '0;

        always @(negedge clk) begin
            beat_t        e;
            beat_t        a;
            logic         exp_rdy;
            logic [255:0] w;
            cyc++;
            if (rst_a[g]) begin
                expq.delete();
                pend.delete();
                nw  = 0;
                pv  = 0;
                run = 0;
            end else begin
                exp_rdy = UPM ? (!m_valid_a[g] || m_ready_a[g])
                              : (expq.size() == 0 || (expq.size() == 1 && m_ready_a[g]));
                chk("s_tready", g, 256'(s_ready_a[g]), 256'(exp_rdy));
                if (pv && !pr) begin
                    chk("hold_valid", g, 256'(m_valid_a[g]), 256'(1));
                    chk("hold_data", g, m_data_a[g], pd);
                    chk("hold_keep_last", g, 256'({m_keep_a[g], m_last_a[g]}), 256'({pk, pl}));
                end
                if (m_valid_a[g] && !pv)
                    chk("latency", g, 256'(cyc - t_acc), 256'(1));
                if (m_valid_a[g] && m_ready_a[g]) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_beat[%0d]: got beat 0x%0h, expected none", g, m_data_a[g]);
                    end else begin
                        e = expq.pop_front();
                        chk("beat_data", g, m_data_a[g], e.d);
                        chk("beat_keep", g, 256'(m_keep_a[g]), 256'(e.k));
                        chk("beat_last", g, 256'(m_last_a[g]), 256'(e.l));
                    end
                    a.d = m_data_a[g];
                    a.k = m_keep_a[g];
                    a.l = m_last_a[g];
                    cap[g].push_back(a);
                end
                run = m_valid_a[g] ? run + 1 : 0;
                if (run > vrun_max[g]) vrun_max[g] = run;
                if (s_valid_a[g] && s_ready_a[g]) begin
                    w = s_data_a[g];
                    if (UPM) begin
                        for (int i = 0; i < WB; i++) pend.push_back(w[8*i +: 8]);
                        nw++;
                        if (nw == AB / WB || s_last_a[g]) begin
                            e.d = '0;
                            e.k = '0;
                            for (int b = 0; b < pend.size(); b++) begin
                                e.d[8*b +: 8] = pend[b];
                                e.k[b] = 1'b1;
                            end
                            e.l = s_last_a[g];
                            expq.push_back(e);
                            pend.delete();
                            nw = 0;
                            t_acc = cyc;
                        end
                    end else begin
                        for (int j = 0; j < WB / AB; j++) begin
                            e.d = '0;
                            e.k = '0;
                            for (int b = 0; b < AB; b++) begin
                                e.d[8*b +: 8] = w[8*(j*AB + b) +: 8];
                                e.k[b] = 1'b1;
                            end
                            e.l = s_last_a[g] && (j == WB / AB - 1);
                            expq.push_back(e);
                        end
                        t_acc = cyc;
                    end
                end
                pv = m_valid_a[g];
                pr = m_ready_a[g];
                pd = m_data_a[g];
                pk = m_keep_a[g];
                pl = m_last_a[g];
            end
            pend_n[g] = expq.size() + pend.size();
        end
    end

    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 3; g++)
            if (rnd_ready[g]) m_ready_a[g] = 1'($urandom_range(0, 1));
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int g, input logic [255:0] w, input logic last);
        int t = 0;
        s_data_a[g]  = w;
        s_last_a[g]  = last;
        s_valid_a[g] = 1'b1;
        @(negedge clk);
        while (!s_ready_a[g] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout[%0d]: s_tready low for %0d cycles, expected high", g, t);
        end
        @(posedge clk);
        #1;
        s_valid_a[g] = 1'b0;
        s_last_a[g]  = 1'b0;
    endtask

    task automatic rand_send(input int g, input int n);
        logic [255:0] w;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 2));
            for (int j = 0; j < 8; j++) w[32*j +: 32] = $urandom;
            send(g, w, (i == n - 1) || ($urandom_range(0, 4) == 0));
        end
    endtask

    function automatic logic [255:0] wup(input int i);
        return 256'((i << 16) | (i - 1));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected test completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] d0, d1, d2;
        for (int g = 0; g < 3; g++) begin
            rst_a[g] = 1'b1; s_valid_a[g] = 1'b0; s_last_a[g] = 1'b0;
            s_data_a[g] = '0; m_ready_a[g] = 1'b1; rnd_ready[g] = 1'b0;
            vrun_max[g] = 0; pend_n[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rst_a[g] = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("reset_data", g, m_data_a[g], 256'(0));
            chk("reset_vld_last_keep", g, 256'({m_valid_a[g], m_last_a[g], m_keep_a[g]}), 256'(0));
            chk("reset_s_tready", g, 256'(s_ready_a[g]), 256'(1));
        end
        @(posedge clk);
        #1;

        // Pass-through, tlast on word 2.
        cap[2].delete();
        send(2, 256'h11111111_22222222_33333333_44444444, 1'b0);
        send(2, 256'h55555555_66666666_77777777_88888888, 1'b1);
        idle(4);
        chk("pass_nbeats", 2, 256'(cap[2].size()), 256'(2));
        chk("pass_beat0", 2, cap[2][0].d, 256'h11111111_22222222_33333333_44444444);
        chk("pass_last0", 2, 256'(cap[2][0].l), 256'(0));
        chk("pass_last1", 2, 256'(cap[2][1].l), 256'(1));
        chk("pass_keep1", 2, 256'(cap[2][1].k), 256'(32'hFFFF));
`ifdef AXIS_Y_PACKER_CNT_EN
        chk("beat_count", 2, 256'(bc_a[2]), 256'(2));
        chk("xfer_count", 2, 256'(xc_a[2]), 256'(1));
`endif

        // Upsize: 8 words, tlast on 8th.
        cap[0].delete();
        for (int i = 1; i <= 8; i++) send(0, wup(i), i == 8);
        idle(4);
        chk("up8_nbeats", 0, 256'(cap[0].size()), 256'(2));
        chk("up8_beat0", 0, cap[0][0].d, 256'h00040003_00030002_00020001_00010000);
        chk("up8_keep0", 0, 256'(cap[0][0].k), 256'(32'hFFFF));
        chk("up8_last0", 0, 256'(cap[0][0].l), 256'(0));
        chk("up8_beat1", 0, cap[0][1].d, 256'h00080007_00070006_00060005_00050004);
        chk("up8_last1", 0, 256'(cap[0][1].l), 256'(1));

        // Upsize: 6 words, partial final beat.
        cap[0].delete();
        for (int i = 1; i <= 6; i++) send(0, wup(i), i == 6);
        idle(4);
        chk("up6_nbeats", 0, 256'(cap[0].size()), 256'(2));
        chk("up6_beat1", 0, cap[0][1].d, 256'h00060005_00050004);
        chk("up6_keep1", 0, 256'(cap[0][1].k), 256'(32'h00FF));
        chk("up6_last1", 0, 256'(cap[0][1].l), 256'(1));

        // Reset after 3 of 4 words discards the partial beat.
        cap[0].delete();
        for (int i = 1; i <= 3; i++) send(0, wup(i), 1'b0);
        rst_a[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_a[0] = 1'b0;
        for (int i = 1; i <= 4; i++) send(0, wup(i), 1'b0);
        idle(4);
        chk("rst_nbeats", 0, 256'(cap[0].size()), 256'(1));
        chk("rst_beat", 0, cap[0][0].d, 256'h00040003_00030002_00020001_00010000);
        chk("rst_last", 0, 256'(cap[0][0].l), 256'(0));

        // Downsize: 3 back-to-back words, no bubbles.
        d0 = 256'h0f0e0d0c_0b0a0908_07060504_03020100;
        d1 = 256'h1f1e1d1c_1b1a1918_17161514_13121110;
        d2 = 256'h2f2e2d2c_2b2a2928_27262524_23222120;
        cap[1].delete();
        vrun_max[1] = 0;
        send(1, d0, 1'b0);
        send(1, d1, 1'b0);
        send(1, d2, 1'b1);
        idle(6);
        chk("down_nbeats", 1, 256'(cap[1].size()), 256'(6));
        chk("down_contig", 1, 256'(vrun_max[1]), 256'(6));
        chk("down_beat0", 1, cap[1][0].d, 256'h07060504_03020100);
        chk("down_beat1", 1, cap[1][1].d, 256'h0f0e0d0c_0b0a0908);
        chk("down_last3", 1, 256'(cap[1][3].l), 256'(0));
        chk("down_last5", 1, 256'(cap[1][5].l), 256'(1));

        // Random traffic with random sink backpressure on all instances.
        for (int g = 0; g < 3; g++) rnd_ready[g] = 1'b1;
        fork
            rand_send(0, 60);
            rand_send(1, 40);
            rand_send(2, 40);
        join
        for (int g = 0; g < 3; g++) rnd_ready[g] = 1'b0;
        idle(2);
        for (int g = 0; g < 3; g++) m_ready_a[g] = 1'b1;
        idle(40);
        for (int g = 0; g < 3; g++) chk("drain_empty", g, 256'(pend_n[g]), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
